neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Single-neuron multiply-accumulate stage that sits directly downstream of a per-neuron weight ROM.
- Accepts a stream of NUM_WEIGHT signed fixed-point activations and fetches the matching weight from the ROM over its read port (ren/radd, one-cycle registered read).
- Accumulates the products at full precision, adds the neuron bias, then saturates and optionally applies ReLU.
- Presents one 16-bit neuron output per input vector on a valid/ready handshake to the next layer.

Parameters:
- NUM_WEIGHT, 10, number of inputs/weights per neuron.
- DATA_WIDTH, 16, width of activations, weights, bias and output (signed two's complement).
- FRAC_BITS, 12, fractional bits of the fixed-point format (1.0 = 16'h1000).
- ADDR_W, $clog2(NUM_WEIGHT), weight address width.
- ACT_RELU, 1, 1 = ReLU applied to the output; 0 = linear output.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_data  in  DATA_WIDTH  activation, signed.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- w_ren  out  1  weight ROM read enable.
- w_radd  out  ADDR_W  weight ROM read address.
- w_dout  in  DATA_WIDTH  weight ROM registered read data, valid one cycle after w_ren.
- bias  in  DATA_WIDTH  neuron bias, signed, same Q format; quasi-static.
- out_data  out  DATA_WIDTH  neuron result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ACC, idx=0, acc=0, mac_pend=0, in_reg=0.
  - out_valid=0, out_data=0.
  - Reset overrides any operation in progress; a partial accumulation is discarded.
- Accept: an input is accepted on any edge where in_valid=1 and in_ready=1.
  - w_ren = in_valid & in_ready (combinational); w_radd = idx.
  - On accept: in_reg<=in_data, mac_pend<=1, idx<=idx+1.
  - On the accept with idx=NUM_WEIGHT-1: idx<=0 and state<=LAST.
- MAC: in any cycle with mac_pend=1, acc <= acc + in_reg*w_dout (signed 2*DATA_WIDTH product, sign-extended into acc).
  - mac_pend clears unless a new accept occurs on the same edge, so back-to-back inputs give one MAC per cycle.
- acc width: 2*DATA_WIDTH+ADDR_W bits, signed; it cannot overflow.
- in_ready = 1 only in state ACC. in_valid gaps are allowed; idx holds across gaps.
- States:
  - ACC: accepting inputs; MAC as above.
  - LAST: in_ready=0; the final pending MAC completes; next state BIAS.
  - BIAS: compute s = (acc + (sign-extended bias << FRAC_BITS)) >>> FRAC_BITS, an arithmetic shift (floor, no rounding).
    - Saturate s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - If ACT_RELU=1 and the result is negative, the result is 0.
    - Register the result to out_data, set out_valid=1, go to OUT.
  - OUT: out_valid=1; out_data stable while out_ready=0.
    - On out_valid & out_ready: out_valid<=0, acc<=0, state<=ACC.
    - in_ready stays 0 for the whole of OUT; there is no input overlap with a pending output.
- Latency: out_valid rises 2 edges after the edge that accepts the last input. Throughput: one result per NUM_WEIGHT+3 cycles minimum.
- bias is sampled in BIAS only.
- w_radd is always idx (0..NUM_WEIGHT-1) and never exceeds NUM_WEIGHT-1.

Test Plan:
- Bench setup: the bench provides a weight ROM model with one-cycle registered read.
- Weights all 16'h1000, 10 back-to-back inputs of 16'h0800, bias 0 -> out_data=16'h5000, out_valid 2 edges after the 10th accept. Repeat with bias=16'h1000 -> 16'h6000.
- Weights all 16'hF000 (-1.0), inputs 16'h0800, bias 0 -> ACT_RELU=0: 16'hB000; ACT_RELU=1: 16'h0000.
- Weights 16'h1000, inputs 16'h1000 (sum 10.0) -> saturates to 16'h7FFF. Weights 16'h1000, inputs 16'hE000 (-2.0) with ACT_RELU=0 -> saturates to 16'h8000.
- in_valid toggled 1/0 every cycle and with random gaps -> same results as the back-to-back case. w_radd sequence is exactly 0..9 with one w_ren per accept.
- out_ready held low for 5 cycles in OUT -> out_data/out_valid stable, in_ready=0, no w_ren. Second vector accepted only after the out handshake; result correct (acc cleared).
- rst_n low for one edge after 4 accepts -> out_valid=0, idx=0. The following 10 inputs of 16'h0800 with weights 16'h1000 give 16'h5000; no residue from the aborted vector.

Source files
------------

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - single-neuron multiply-accumulate with bias, saturation and optional ReLU
//
// Purpose:
//   Consumes NUM_WEIGHT signed fixed-point activations and fetches the
//   matching weight from an external ROM with a one-cycle registered read.
//   The products are accumulated at full precision. The bias is then added
//   and the sum is scaled back to the Q format. The result is saturated,
//   optionally passed through ReLU, and held on a valid/ready output until
//   the next layer accepts it.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_data/valid/ready activation stream (signed), accepted when valid & ready
//   w_ren, w_radd       weight ROM read request, issued with each accept
//   w_dout              weight ROM data, valid the cycle after w_ren
//   bias                neuron bias (signed, same Q format), sampled in BIAS only
//   out_data/valid      neuron result, held until out_ready
//   out_ready           downstream accept
module neuron_mac #(
   parameter int NUM_WEIGHT = 10,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 12,
   parameter int ADDR_W     = $clog2(NUM_WEIGHT),
   parameter int ACT_RELU   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  w_ren,
   output logic [ADDR_W-1:0]     w_radd,
   input  logic [DATA_WIDTH-1:0] w_dout,
   input  logic [DATA_WIDTH-1:0] bias,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int ACC_W = 2*DATA_WIDTH + ADDR_W;
   // One extra bit so that adding the scaled bias to an extreme
   // accumulator value cannot wrap.
   localparam int SUM_W = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**(DATA_WIDTH-1) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(DATA_WIDTH-1)));
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHT-1);

   typedef enum logic [1:0] {ACC, LAST, BIAS, OUT} state_t;

   state_t                        state_q, state_d;
   logic [ADDR_W-1:0]             idx_q, idx_d;
   logic signed [ACC_W-1:0]       acc_q, acc_d;
   logic                          mac_pend_q, mac_pend_d;
   logic signed [DATA_WIDTH-1:0]  in_reg_q, in_reg_d;
   logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
   logic                          out_valid_q, out_valid_d;

   logic                          accept;
   logic signed [DATA_WIDTH-1:0]  w_s;
   logic signed [DATA_WIDTH-1:0]  bias_s;
   logic signed [2*DATA_WIDTH-1:0] product;
   logic signed [SUM_W-1:0]       biased;
   logic signed [SUM_W-1:0]       shifted;
   logic signed [DATA_WIDTH-1:0]  result;

   assign in_ready  = (state_q == ACC);
   assign accept    = in_valid & in_ready;
   assign w_ren     = accept;
   assign w_radd    = idx_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

   assign w_s     = $signed(w_dout);
   assign bias_s  = $signed(bias);
   // in_reg_q holds the activation whose weight arrives on w_dout this cycle.
   assign product = in_reg_q * w_s;

   // Bias is moved to the product's scale (2*FRAC_BITS fractional bits)
   // before the add; the arithmetic right shift then floors back to Q format.
   always_comb begin
      biased  = SUM_W'(acc_q) + (SUM_W'(bias_s) <<< FRAC_BITS);
      shifted = biased >>> FRAC_BITS;
      if (shifted > SAT_MAX) begin
         result = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         result = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         result = shifted[DATA_WIDTH-1:0];
      end
      if ((ACT_RELU != 0) && (result < 0)) begin
         result = '0;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      mac_pend_d  = 1'b0;
      in_reg_d    = in_reg_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (mac_pend_q) begin
         acc_d = acc_q + ACC_W'(product);
      end

      if (accept) begin
         in_reg_d   = $signed(in_data);
         mac_pend_d = 1'b1;
         if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LAST;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      case (state_q)
         LAST: state_d = BIAS;
         BIAS: begin
            out_data_d  = result;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               state_d     = ACC;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ACC;
         idx_q       <= '0;
         acc_q       <= '0;
         mac_pend_q  <= 1'b0;
         in_reg_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         mac_pend_q  <= mac_pend_d;
         in_reg_q    <= in_reg_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - scoreboard bench for neuron_mac (ReLU and linear instances)
module tb_neuron_mac;

   localparam int NW = 10;
   localparam int DW = 16;
   localparam int AW = $clog2(NW);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic [DW-1:0] bias;
   logic          out_ready;

   logic          in_ready_r, w_ren_r, out_valid_r;
   logic [AW-1:0] w_radd_r;
   logic [DW-1:0] w_dout_r, out_data_r;
   logic          in_ready_l, w_ren_l, out_valid_l;
   logic [AW-1:0] w_radd_l;
   logic [DW-1:0] w_dout_l, out_data_l;

   logic signed [DW-1:0] rom [NW];
   logic signed [DW-1:0] vin [NW];

   logic [DW-1:0] q_r [$];
   logic [DW-1:0] q_l [$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   neuron_mac #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW), .FRAC_BITS(12), .ACT_RELU(1)) dut_r (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_r),
      .w_ren(w_ren_r), .w_radd(w_radd_r), .w_dout(w_dout_r), .bias(bias),
      .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(out_ready)
   );

   neuron_mac #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW), .FRAC_BITS(12), .ACT_RELU(0)) dut_l (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
      .w_ren(w_ren_l), .w_radd(w_radd_l), .w_dout(w_dout_l), .bias(bias),
      .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready)
   );

   // Weight ROMs with one-cycle registered read.
   always @(posedge clk) begin
      if (w_ren_r) w_dout_r <= rom[w_radd_r];
      if (w_ren_l) w_dout_l <= rom[w_radd_l];
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: dot product, bias scaled by 2^12, floor divide by 2^12,
   // clamp to 16-bit signed, optional ReLU.
   function automatic logic [DW-1:0] model(input int relu, input logic signed [DW-1:0] b);
      longint s = 0;
      for (int i = 0; i < NW; i++) s += longint'(vin[i]) * longint'(rom[i]);
      s += longint'(b) * 4096;
      s = s >>> 12;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu != 0 && s < 0) s = 0;
      return s[DW-1:0];
   endfunction

   // Monitor: scoreboard pops, address sequence, hold and no-overlap checks.
   int            exp_addr = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_addr   = 0;
         prev_stall = 1'b0;
      end else begin
         check("w_ren", w_ren_r, in_valid & in_ready_r);
         check("lin_ready_match", in_ready_l, in_ready_r);
         if (w_ren_r) begin
            check("w_radd", w_radd_r, exp_addr);
            exp_addr = (exp_addr + 1) % NW;
         end
         if (prev_stall) begin
            check("hold_valid", out_valid_r, 1);
            check("hold_data", out_data_r, prev_data);
         end
         if (out_valid_r) begin
            check("out_in_ready", in_ready_r, 0);
            check("out_w_ren", w_ren_r, 0);
         end
         if (out_valid_r && out_ready) begin
            if (q_r.size() == 0) check("relu_unexpected_out", 1, 0);
            else check("relu_out", out_data_r, q_r.pop_front());
         end
         if (out_valid_l && out_ready) begin
            if (q_l.size() == 0) check("lin_unexpected_out", 1, 0);
            else check("lin_out", out_data_l, q_l.pop_front());
         end
         prev_stall = out_valid_r & ~out_ready;
         prev_data  = out_data_r;
      end
   end

   task automatic accept_one(input logic [DW-1:0] x, input int gap);
      int   cyc;
      logic rdy;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = x;
      cyc      = 0;
      forever begin
         rdy = in_ready_r;
         @(posedge clk); #1;
         if (rdy) break;
         cyc++;
         if (cyc > 50) begin check("accept_timeout", 0, 1); break; end
      end
      in_valid = 1'b0;
   endtask

   // mode 0: back-to-back, 1: alternate valid, 2: random gaps.
   task automatic send_vec(input int mode, input int stall, input logic [DW-1:0] er,
                           input logic [DW-1:0] el);
      int lat;
      for (int i = 0; i < NW; i++) begin
         accept_one(vin[i], (mode == 0 || i == 0) ? 0 : (mode == 1 ? 1 : $urandom_range(0, 3)));
      end
      q_r.push_back(er);
      q_l.push_back(el);
      lat = 0;
      while (!out_valid_r && lat < 20) begin @(posedge clk); #1; lat++; end
      check("latency", lat, 2);
      if (stall != 0) begin
         out_ready = 1'b0;
         repeat (5) begin @(posedge clk); #1; end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("valid_clear", out_valid_r, 0);
      check("ready_back", in_ready_r, 1);
   endtask

   task automatic run_const(input logic [DW-1:0] w, input logic [DW-1:0] x, input logic [DW-1:0] b,
                            input logic [DW-1:0] er, input logic [DW-1:0] el,
                            input int mode, input int stall);
      for (int i = 0; i < NW; i++) begin rom[i] = w; vin[i] = x; end
      bias = b;
      send_vec(mode, stall, er, el);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      bias      = '0;
      out_ready = 1'b1;
      for (int i = 0; i < NW; i++) begin rom[i] = '0; vin[i] = '0; end
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid_r, 0);
      check("rst_out_data", out_data_r, 0);
      check("rst_in_ready", in_ready_r, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_const(16'h1000, 16'h0800, 16'h0000, 16'h5000, 16'h5000, 0, 0);
      run_const(16'h1000, 16'h0800, 16'h1000, 16'h6000, 16'h6000, 0, 0);
      run_const(16'hF000, 16'h0800, 16'h0000, 16'h0000, 16'hB000, 0, 0);
      run_const(16'h1000, 16'h1000, 16'h0000, 16'h7FFF, 16'h7FFF, 0, 0);
      run_const(16'h1000, 16'hE000, 16'h0000, 16'h0000, 16'h8000, 0, 0);
      run_const(16'h1000, 16'h0800, 16'h0000, 16'h5000, 16'h5000, 1, 0);
      run_const(16'h1000, 16'h0800, 16'h0000, 16'h5000, 16'h5000, 2, 0);
      run_const(16'h1000, 16'h0800, 16'h1000, 16'h6000, 16'h6000, 0, 1);
      run_const(16'h1000, 16'h0800, 16'h0000, 16'h5000, 16'h5000, 0, 0);

      // Abort a vector after 4 accepts.
      for (int i = 0; i < NW; i++) rom[i] = 16'h1000;
      for (int i = 0; i < 4; i++) accept_one(16'h7000, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_out_valid", out_valid_r, 0);
      check("abort_in_ready", in_ready_r, 1);
      run_const(16'h1000, 16'h0800, 16'h0000, 16'h5000, 16'h5000, 0, 0);

      for (int v = 0; v < 24; v++) begin
         logic signed [DW-1:0] b;
         for (int i = 0; i < NW; i++) begin
            rom[i] = DW'($urandom);
            vin[i] = DW'($urandom);
         end
         b    = DW'($urandom);
         bias = b;
         send_vec(v % 3, (v % 4) == 3 ? 1 : 0, model(1, b), model(0, b));
      end

      repeat (3) @(posedge clk);
      #1;
      check("relu_queue_empty", q_r.size(), 0);
      check("lin_queue_empty", q_l.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
